// File: rtl/syn_run_control_pkg.sv
// Shared definitions for the run-control sequencer: FSM encodings and
// counter-select codes.
package syn_run_control_pkg;

  localparam int unsigned RC_STATE_BIT = 2;
  localparam int unsigned STAT_NUM     = 4;

  typedef enum logic [RC_STATE_BIT-1:0] {
    RC_IDLE   = 2'd0,
    RC_RUN    = 2'd1,
    RC_STEP   = 2'd2,
    RC_HALTED = 2'd3
  } rc_state_e;

  localparam logic [1:0] STAT_SEL_CYCLES = 2'd0;
  localparam logic [1:0] STAT_SEL_JUMPS  = 2'd1;
  localparam logic [1:0] STAT_SEL_BRANCH = 2'd2;
  localparam logic [1:0] STAT_SEL_TAKEN  = 2'd3;

endpackage

// File: rtl/syn_stat_counter.sv
// Wrap-around event counter with synchronous clear taking priority over increment.
module syn_stat_counter #(
  parameter int unsigned CntBit = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [CntBit-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CntBit'(1);
    end
  end

endmodule

// File: rtl/syn_run_control.sv
// Run/step/stop/breakpoint sequencer gating the CPU enable, plus
// performance counters behind a registered select port.
module syn_run_control
  import syn_run_control_pkg::*;
#(
  parameter int unsigned CntBit = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  input  logic                    step,
  input  logic                    stop,
  input  logic                    clr_stat,
  input  logic                    bp_en,
  input  logic [31:0]             bp_addr,
  input  logic [31:0]             pc_dbg,
  input  logic                    halt,
  input  logic                    jumped,
  input  logic                    is_branch,
  input  logic                    branched,
  input  logic [1:0]              stat_sel,
  output logic                    cpu_en,
  output logic [RC_STATE_BIT-1:0] state,
  output logic                    bp_hit_flag,
  output logic [CntBit-1:0]       stat_data
);

  rc_state_e          state_q, state_d;
  logic               skip_q, skip_d;
  logic               flag_d;
  logic               bp_hit_c;
  logic [STAT_NUM-1:0] inc_c;
  logic [CntBit-1:0]  cnt [STAT_NUM];

  // skip masks the breakpoint for the first instruction after a resume
  assign bp_hit_c = bp_en && (pc_dbg == bp_addr) && !skip_q;
  assign state    = state_q;

  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      RC_RUN:  cpu_en = !halt && !bp_hit_c;
      RC_STEP: cpu_en = !halt;
      default: cpu_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q && !cpu_en;
    flag_d  = bp_hit_flag;
    case (state_q)
      RC_IDLE: begin
        if (!stop && step) begin
          state_d = RC_STEP;
          skip_d  = 1'b1;
        end else if (!stop && go) begin
          state_d = RC_RUN;
          skip_d  = 1'b1;
          flag_d  = 1'b0;
        end
      end
      RC_RUN: begin
        if (halt) begin
          state_d = RC_HALTED;
        end else if (bp_hit_c) begin
          state_d = RC_IDLE;
          flag_d  = 1'b1;
        end else if (stop) begin
          state_d = RC_IDLE;
        end
      end
      RC_STEP: begin
        state_d = halt ? RC_HALTED : RC_IDLE;
      end
      default: state_d = RC_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RC_IDLE;
      skip_q      <= 1'b0;
      bp_hit_flag <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      bp_hit_flag <= flag_d;
    end
  end

  // Counter order matches stat_sel: cycles, jumps, branches, taken branches
  assign inc_c = {branched, is_branch, jumped, 1'b1} & {STAT_NUM{cpu_en}};

  for (genvar i = 0; i < STAT_NUM; i++) begin : g_cnt
    syn_stat_counter #(.CntBit(CntBit)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_stat),
      .inc   (inc_c[i]),
      .count (cnt[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_data <= '0;
    end else begin
      stat_data <= cnt[stat_sel];
    end
  end

endmodule

// File: tb/tb_syn_run_control.sv
// Scoreboard bench for syn_run_control: a behavioural core/sequencer model
// queues expected outputs per cycle and a monitor compares them.
module tb_syn_run_control;

  localparam int unsigned CNT_BIT = 4;
  localparam int          CNT_MASK = (1 << CNT_BIT) - 1;

  logic               clk;
  logic               rst_n;
  logic               go, step, stop, clr_stat, bp_en;
  logic [31:0]        bp_addr, pc_dbg;
  logic               halt, jumped, is_branch, branched;
  logic [1:0]         stat_sel;
  logic               cpu_en;
  logic [1:0]         state;
  logic               bp_hit_flag;
  logic [CNT_BIT-1:0] stat_data;

  syn_run_control #(.CntBit(CNT_BIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .step        (step),
    .stop        (stop),
    .clr_stat    (clr_stat),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc_dbg      (pc_dbg),
    .halt        (halt),
    .jumped      (jumped),
    .is_branch   (is_branch),
    .branched    (branched),
    .stat_sel    (stat_sel),
    .cpu_en      (cpu_en),
    .state       (state),
    .bp_hit_flag (bp_hit_flag),
    .stat_data   (stat_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic               en;
    logic [1:0]         st;
    logic               flag;
    logic [CNT_BIT-1:0] stat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Stimulus for the next cycle; pulses auto-clear after each tick
  logic        s_go, s_step, s_stop, s_clr, s_bp_en;
  logic        s_halt, s_jumped, s_is_branch, s_branched;
  logic [31:0] s_bp_addr, s_target;
  logic [1:0]  s_sel;

  // Reference model: operating mode flags, resume mask, counters, core PC
  bit          m_running, m_stepping, m_halted, m_skip, m_flag;
  int          m_cnt[4];
  int          m_stat;
  logic [31:0] core_pc;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endfunction

  function automatic logic [1:0] mode_code();
    if (m_halted)        return 2'd3;
    else if (m_stepping) return 2'd2;
    else if (m_running)  return 2'd1;
    else                 return 2'd0;
  endfunction

  task automatic clear_stim();
    s_go = 0; s_step = 0; s_stop = 0; s_clr = 0; s_bp_en = 0;
    s_halt = 0; s_jumped = 0; s_is_branch = 0; s_branched = 0;
    s_bp_addr = '0; s_target = '0; s_sel = 2'd0;
  endtask

  task automatic apply_inputs();
    go = s_go; step = s_step; stop = s_stop; clr_stat = s_clr;
    bp_en = s_bp_en; bp_addr = s_bp_addr; pc_dbg = core_pc;
    halt = s_halt; jumped = s_jumped; is_branch = s_is_branch;
    branched = s_branched; stat_sel = s_sel;
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    m_running = 0; m_stepping = 0; m_halted = 0; m_skip = 0; m_flag = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_stat = 0;
    core_pc = '0;
    clear_stim();
    apply_inputs();
    e = '{en: 1'b0, st: 2'd0, flag: 1'b0, stat: '0};
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    bit   hit, en, ev_jump, ev_br, ev_taken;
    @(negedge clk);
    rst_n = 1'b1;
    apply_inputs();
    // The core only commits while running/stepping and not halting
    hit = s_bp_en && (core_pc == s_bp_addr) && !m_skip;
    en  = (m_running && !s_halt && !hit) || (m_stepping && !s_halt);
    e.en = en; e.st = mode_code(); e.flag = m_flag; e.stat = CNT_BIT'(m_stat);
    exp_q.push_back(e);

    m_stat = m_cnt[s_sel];
    ev_jump = s_jumped; ev_br = s_is_branch; ev_taken = s_branched;
    if (s_clr) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (en) begin
      m_cnt[0] = (m_cnt[0] + 1) & CNT_MASK;
      if (ev_jump)  m_cnt[1] = (m_cnt[1] + 1) & CNT_MASK;
      if (ev_br)    m_cnt[2] = (m_cnt[2] + 1) & CNT_MASK;
      if (ev_taken) m_cnt[3] = (m_cnt[3] + 1) & CNT_MASK;
    end

    if (en) m_skip = 0;
    if (m_halted) begin
      // frozen until reset
    end else if ((m_running || m_stepping) && s_halt) begin
      m_halted = 1; m_running = 0; m_stepping = 0;
    end else if (m_stepping) begin
      m_stepping = 0;
    end else if (m_running) begin
      if (hit) begin
        m_running = 0; m_flag = 1;
      end else if (s_stop) begin
        m_running = 0;
      end
    end else if (!s_stop && s_step) begin
      m_stepping = 1; m_skip = 1;
    end else if (!s_stop && s_go) begin
      m_running = 1; m_skip = 1; m_flag = 0;
    end

    if (en) core_pc = (s_jumped || s_branched) ? s_target : ((core_pc + 32'd4) & 32'h3F);
    s_go = 0; s_step = 0; s_stop = 0; s_clr = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("cpu_en",      int'(cpu_en),      int'(e.en));
        check("state",       int'(state),       int'(e.st));
        check("bp_hit_flag", int'(bp_hit_flag), int'(e.flag));
        check("stat_data",   int'(stat_data),   int'(e.stat));
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    clear_stim();
    core_pc = '0;
    apply_inputs();

    // Three single steps from PC 0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s_step = 1; tick(); tick(); tick();
    end
    tick();

    // Breakpoint at 0x10, then resume past it
    do_reset();
    s_bp_en = 1; s_bp_addr = 32'h10; s_go = 1;
    repeat (8) begin s_bp_en = 1; s_bp_addr = 32'h10; tick(); end
    s_go = 1;
    repeat (4) begin s_bp_en = 1; s_bp_addr = 32'h10; tick(); end
    s_stop = 1; tick(); tick();

    // Stop coincident with the instruction at 0x20
    do_reset();
    s_go = 1; tick();
    for (int i = 0; i < 40 && core_pc != 32'h20; i++) tick();
    s_stop = 1; tick(); tick(); tick();

    // Branch/jump mix, read back counters, then clear while running
    do_reset();
    s_go = 1; tick();
    for (int i = 0; i < 8; i++) begin
      s_is_branch = (i < 5); s_branched = (i < 3); s_jumped = (i == 5 || i == 6);
      s_target = core_pc + 32'd4;
      tick();
    end
    s_is_branch = 0; s_branched = 0; s_jumped = 0;
    s_stop = 1; tick();
    for (int sel = 1; sel < 4; sel++) begin
      s_sel = 2'(sel); tick(); tick();
    end
    s_sel = 0; s_go = 1; tick(); tick();
    s_clr = 1; tick(); tick(); tick();

    // Halt together with stop, then ignored commands
    do_reset();
    s_go = 1; tick(); tick(); tick();
    s_halt = 1; s_stop = 1; tick();
    s_halt = 0; s_go = 1; tick();
    s_step = 1; tick(); tick(); tick();

    // Cycle counter wrap, then reset mid-run
    do_reset();
    s_go = 1; tick();
    repeat (20) tick();
    do_reset();
    tick(); tick();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        s_go        = ($urandom_range(0, 7) == 0);
        s_step      = ($urandom_range(0, 9) == 0);
        s_stop      = ($urandom_range(0, 11) == 0);
        s_clr       = ($urandom_range(0, 39) == 0);
        s_bp_en     = ($urandom_range(0, 2) != 0);
        s_bp_addr   = 32'($urandom_range(0, 15)) << 2;
        s_halt      = ($urandom_range(0, 199) == 0);
        s_is_branch = ($urandom_range(0, 3) == 0);
        s_branched  = s_is_branch && ($urandom_range(0, 1) == 1);
        s_jumped    = !s_is_branch && ($urandom_range(0, 7) == 0);
        s_target    = 32'($urandom_range(0, 15)) << 2;
        s_sel       = 2'($urandom_range(0, 3));
        tick();
      end
    end

    repeat (2) @(negedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
